// File: rtl/lcd_byte_writer_pkg.sv
// Shared HD44780 definitions for the character-LCD path: default timing,
// writer FSM state encoding and the common command codes.
package lcd_byte_writer_pkg;

    // Default timing in 50 MHz clock cycles.
    localparam int T_SETUP = 2;      // 40 ns
    localparam int T_PULSE = 12;     // 240 ns
    localparam int T_GAP   = 50;     // 1 us
    localparam int T_EXEC  = 2000;   // 40 us
    localparam int T_CLEAR = 82000;  // 1.64 ms
    localparam int CNT_W   = 17;

    typedef enum logic [2:0] {
        ST_WAIT_INIT = 3'd0,
        ST_IDLE      = 3'd1,
        ST_HI_SETUP  = 3'd2,
        ST_HI_PULSE  = 3'd3,
        ST_GAP       = 3'd4,
        ST_LO_SETUP  = 3'd5,
        ST_LO_PULSE  = 3'd6,
        ST_EXEC      = 3'd7
    } state_t;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_FUNC    = 8'h28;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    // Clear and return-home (0x01..0x03) need the long execution wait; 0x00 does not.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Byte writer for a 4-bit HD44780 bus: passes the init stage through until it
// reports done, then sends handshaked bytes as two timed nibbles plus an exec wait.
module lcd_byte_writer #(
    parameter int T_SETUP = lcd_byte_writer_pkg::T_SETUP,
    parameter int T_PULSE = lcd_byte_writer_pkg::T_PULSE,
    parameter int T_GAP   = lcd_byte_writer_pkg::T_GAP,
    parameter int T_EXEC  = lcd_byte_writer_pkg::T_EXEC,
    parameter int T_CLEAR = lcd_byte_writer_pkg::T_CLEAR,
    parameter int CNT_W   = lcd_byte_writer_pkg::CNT_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_init_sf_d,
    input  logic       i_init_e,
    input  logic       i_init_done,
    input  logic       i_wr_valid,
    input  logic       i_wr_rs,
    input  logic [7:0] i_wr_data,
    output logic       o_wr_ready,
    output logic [3:0] o_sf_d,
    output logic       o_lcd_e,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw
);
    import lcd_byte_writer_pkg::*;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_limit;
    logic             w_timed;
    logic             w_cnt_hit;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_rs, w_rs_nxt;
    logic [3:0]       r_sf_d, w_sf_d_nxt;
    logic             r_lcd_e, w_lcd_e_nxt;
    logic             r_done, w_done_nxt;
    logic             w_pass;

    always_comb begin
        w_limit = CNT_W'(1);
        w_timed = 1'b1;
        case (r_state)
            ST_HI_SETUP, ST_LO_SETUP: w_limit = CNT_W'(T_SETUP);
            ST_HI_PULSE, ST_LO_PULSE: w_limit = CNT_W'(T_PULSE);
            ST_GAP:                   w_limit = CNT_W'(T_GAP);
            ST_EXEC:                  w_limit = is_slow_cmd(r_rs, r_data) ? CNT_W'(T_CLEAR)
                                                                          : CNT_W'(T_EXEC);
            default:                  w_timed = 1'b0;
        endcase
    end

    assign w_cnt_hit = w_timed && (r_cnt == w_limit - 1'b1);

    // NOTE: every next-value signal takes its hold value first, so no path through the case can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_rs_nxt    = r_rs;
        w_sf_d_nxt  = r_sf_d;
        w_lcd_e_nxt = r_lcd_e;
        w_done_nxt  = r_done;
        case (r_state)
            ST_WAIT_INIT: if (i_init_done) begin
                w_done_nxt  = 1'b1;
                w_lcd_e_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                w_lcd_e_nxt = 1'b0;
                if (i_wr_valid) begin
                    w_data_nxt  = i_wr_data;
                    w_rs_nxt    = i_wr_rs;
                    w_sf_d_nxt  = i_wr_data[7:4];
                    w_state_nxt = ST_HI_SETUP;
                end
            end
            ST_HI_SETUP: if (w_cnt_hit) begin
                w_lcd_e_nxt = 1'b1;
                w_state_nxt = ST_HI_PULSE;
            end
            ST_HI_PULSE: if (w_cnt_hit) begin
                w_lcd_e_nxt = 1'b0;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: if (w_cnt_hit) begin
                w_sf_d_nxt  = r_data[3:0];
                w_state_nxt = ST_LO_SETUP;
            end
            ST_LO_SETUP: if (w_cnt_hit) begin
                w_lcd_e_nxt = 1'b1;
                w_state_nxt = ST_LO_PULSE;
            end
            ST_LO_PULSE: if (w_cnt_hit) begin
                w_lcd_e_nxt = 1'b0;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: if (w_cnt_hit) begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_WAIT_INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_WAIT_INIT;
            r_cnt   <= '0;
            r_data  <= '0;
            r_rs    <= 1'b0;
            r_sf_d  <= '0;
            r_lcd_e <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_rs    <= w_rs_nxt;
            r_sf_d  <= w_sf_d_nxt;
            r_lcd_e <= w_lcd_e_nxt;
            r_done  <= w_done_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_timed) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // The init stage owns the pins until done; reset forces them low regardless of its bus.
    assign w_pass     = !r_done && i_rst_n;
    assign o_sf_d     = w_pass ? i_init_sf_d : r_sf_d;
    assign o_lcd_e    = w_pass ? i_init_e    : r_lcd_e;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_wr_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: pass-through table, byte table with a scoreboard
// checked by a pin monitor, plus back-to-back and async-reset sequences.
module tb_lcd_byte_writer;
    import lcd_byte_writer_pkg::*;

    localparam int SETUP = 2;
    localparam int PULSE = 12;
    localparam int GAP   = 50;
    localparam int EXEC  = 400;
    localparam int CLEAR = 1600;
    localparam int LAT_X = SETUP + PULSE + GAP + SETUP + PULSE + EXEC;   // 478
    localparam int LAT_C = SETUP + PULSE + GAP + SETUP + PULSE + CLEAR;  // 1678
    localparam int WAIT_MAX = 4000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] init_sf_d = 4'h0;
    logic       init_e = 1'b0;
    logic       init_done = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic [3:0] sf_d;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;

    always #5 clk = ~clk;

    lcd_byte_writer #(
        .T_SETUP(SETUP), .T_PULSE(PULSE), .T_GAP(GAP),
        .T_EXEC(EXEC), .T_CLEAR(CLEAR), .CNT_W(17)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_init_sf_d(init_sf_d), .i_init_e(init_e), .i_init_done(init_done),
        .i_wr_valid(wr_valid), .i_wr_rs(wr_rs), .i_wr_data(wr_data),
        .o_wr_ready(wr_ready), .o_sf_d(sf_d), .o_lcd_e(lcd_e),
        .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [3:0] hi;
        logic [3:0] lo;
        int         lat;
    } byte_vec_t;

    typedef struct {
        logic [3:0] init_sf_d;
        logic       init_e;
        logic       wr_valid;
        logic [3:0] exp_sf_d;
        logic       exp_e;
    } pass_vec_t;

    byte_vec_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pin monitor: k counts clock edges since the accept edge.
    bit         m_busy = 0, m_pend = 0, m_prev_e = 0;
    int         m_k, m_pulses, m_w1, m_w2, m_rise1, m_rise2;
    int         m_pre_hi, m_gap_hi, m_gap_lo, m_rs_bad, m_unstable;
    logic [3:0] m_n1, m_n2;

    task automatic finish_txn();
        byte_vec_t e;
        string     t;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        t = $sformatf("[%0d:%02h]", e.rs, e.data);
        check({"latency", t}, m_k, e.lat);
        check({"pulses", t}, m_pulses, 2);
        check({"hi_rise", t}, m_rise1, SETUP);
        check({"lo_rise", t}, m_rise2, SETUP + PULSE + GAP + SETUP);
        check({"hi_width", t}, m_w1, PULSE);
        check({"lo_width", t}, m_w2, PULSE);
        check({"hi_nibble", t}, m_n1, e.hi);
        check({"lo_nibble", t}, m_n2, e.lo);
        check({"hi_setup", t}, m_pre_hi, SETUP);
        check({"gap_hi", t}, m_gap_hi, GAP + ((e.hi == e.lo) ? SETUP : 0));
        check({"gap_lo", t}, m_gap_lo, SETUP + ((e.hi == e.lo) ? GAP : 0));
        check({"rs_rw_bad", t}, m_rs_bad, 0);
        check({"nibble_unstable", t}, m_unstable, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0;
                m_pend = 0;
            end else begin
                if (m_pend) begin
                    m_busy = 1; m_pend = 0; m_k = 0; m_prev_e = 0;
                    m_pulses = 0; m_w1 = 0; m_w2 = 0; m_rise1 = -1; m_rise2 = -1;
                    m_pre_hi = 0; m_gap_hi = 0; m_gap_lo = 0; m_rs_bad = 0; m_unstable = 0;
                    m_n1 = 4'hx; m_n2 = 4'hx;
                end else if (m_busy) begin
                    m_k++;
                end
                if (m_busy && sb_q.size() > 0) begin
                    if (lcd_rs !== sb_q[0].rs || lcd_rw !== 1'b0) m_rs_bad++;
                    if (lcd_e) begin
                        if (!m_prev_e) begin
                            m_pulses++;
                            if (m_pulses == 1) begin m_rise1 = m_k; m_n1 = sf_d; end
                            else begin m_rise2 = m_k; m_n2 = sf_d; end
                        end
                        if (m_pulses == 1) begin
                            m_w1++;
                            if (sf_d !== sb_q[0].hi) m_unstable++;
                        end else begin
                            m_w2++;
                            if (sf_d !== sb_q[0].lo) m_unstable++;
                        end
                    end else begin
                        if (m_pulses == 0 && sf_d === sb_q[0].hi) m_pre_hi++;
                        if (m_pulses == 1 && sf_d === sb_q[0].hi) m_gap_hi++;
                        if (m_pulses == 1 && sf_d === sb_q[0].lo) m_gap_lo++;
                    end
                    m_prev_e = lcd_e;
                end
                if (m_busy && wr_ready) begin
                    finish_txn();
                    m_busy = 0;
                end
                if (wr_valid && wr_ready) m_pend = 1;
            end
        end
    end

    // Returns the number of negedges seen with WR_READY low before the accept edge.
    task automatic wait_accept(output int n);
        bit ok;
        n = 0;
        ok = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            if (wr_ready === 1'b1) begin
                ok = 1;
                break;
            end
            n++;
        end
        if (!ok) check("accept_timeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            if (wr_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input byte_vec_t v);
        int n;
        wr_rs    = v.rs;
        wr_data  = v.data;
        wr_valid = 1'b1;
        sb_q.push_back(v);
        wait_accept(n);
        wr_valid = 1'b0;
        wr_rs    = ~v.rs;
        wr_data  = ~v.data;
    endtask

    pass_vec_t pv[4];
    byte_vec_t bv[7];
    byte_vec_t b2b_a, b2b_b, rst_v;

    initial begin
        int n;
        bit seen;

        pv[0] = '{4'h3, 1'b1, 1'b1, 4'h3, 1'b1};
        pv[1] = '{4'h3, 1'b1, 1'b0, 4'h3, 1'b1};
        pv[2] = '{4'hC, 1'b0, 1'b1, 4'hC, 1'b0};
        pv[3] = '{4'h5, 1'b1, 1'b1, 4'h5, 1'b1};

        bv[0] = '{1'b1, 8'h41,     4'h4, 4'h1, LAT_X};
        bv[1] = '{1'b0, CMD_CLEAR, 4'h0, 4'h1, LAT_C};
        bv[2] = '{1'b0, CMD_FUNC,  4'h2, 4'h8, LAT_X};
        bv[3] = '{1'b0, 8'h00,     4'h0, 4'h0, LAT_X};
        bv[4] = '{1'b0, 8'h03,     4'h0, 4'h3, LAT_C};
        bv[5] = '{1'b0, 8'h04,     4'h0, 4'h4, LAT_X};
        bv[6] = '{1'b1, CMD_HOME,  4'h0, 4'h2, LAT_X};

        b2b_a = '{1'b1, 8'h48, 4'h4, 4'h8, LAT_X};
        b2b_b = '{1'b1, 8'h49, 4'h4, 4'h9, LAT_X};
        rst_v = '{1'b1, 8'h41, 4'h4, 4'h1, LAT_X};

        // Reset holds every output low even with the init bus active.
        init_sf_d = 4'hA;
        init_e    = 1'b1;
        #3;
        check("rst_sf_d", sf_d, 0);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_wr_ready", wr_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pre-init pass-through; WR_VALID must be ignored.
        wr_data = 8'hFF;
        wr_rs   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            init_sf_d = pv[i].init_sf_d;
            init_e    = pv[i].init_e;
            wr_valid  = pv[i].wr_valid;
            @(negedge clk);
            check($sformatf("pass_sf_d[%0d]", i), sf_d, pv[i].exp_sf_d);
            check($sformatf("pass_lcd_e[%0d]", i), lcd_e, pv[i].exp_e);
            check($sformatf("pass_lcd_rs[%0d]", i), lcd_rs, 0);
            check($sformatf("pass_ready[%0d]", i), wr_ready, 0);
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;

        // Handover: done is sampled at the next edge, then pins belong to the writer.
        init_done = 1'b1;
        @(negedge clk);
        check("handover_ready_before", wr_ready, 0);
        @(negedge clk);
        check("handover_ready", wr_ready, 1);
        check("handover_lcd_e", lcd_e, 0);
        check("handover_sf_d", sf_d, 0);
        @(posedge clk);
        #1;
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        check("done_sticky_ready", wr_ready, 1);
        check("done_sticky_lcd_e", lcd_e, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            send(bv[i]);
            wait_idle();
        end

        // Back-to-back: second byte accepted on the cycle WR_READY returns.
        wr_rs    = b2b_a.rs;
        wr_data  = b2b_a.data;
        wr_valid = 1'b1;
        sb_q.push_back(b2b_a);
        wait_accept(n);
        wr_data = b2b_b.data;
        sb_q.push_back(b2b_b);
        wait_accept(n);
        check("b2b_accept_spacing", n, LAT_X);
        wr_valid = 1'b0;
        wait_idle();

        // Async reset in the high-nibble pulse.
        send(rst_v);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_e === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("rst_test_pulse_seen", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_lcd_e", lcd_e, 0);
        check("async_rst_sf_d", sf_d, 0);
        check("async_rst_lcd_rs", lcd_rs, 0);
        check("async_rst_lcd_rw", lcd_rw, 0);
        check("async_rst_ready", wr_ready, 0);
        sb_q.delete();
        init_sf_d = 4'h0;
        init_e    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_ready[%0d]", i), wr_ready, 0);
        end
        @(posedge clk);
        #1;
        init_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reinit_ready", wr_ready, 1);
        @(posedge clk);
        #1;
        send(rst_v);
        wait_idle();

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
